// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressable data memory with configurable response latency
// IDLE/WAIT/RESP handshake; memory access and response registers both update on the edge entering RESP.
module dmem_responder #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  l_we;
    logic [DM_ADDRESS-1:0] l_addr;
    logic [DATA_W-1:0]     l_wdata;
    logic [2:0]            l_f3;

    logic [DATA_W-1:0]     mem [2**(DM_ADDRESS-2)];

    logic                  accept, enter_resp, wr_en, err;
    logic                  op_we;
    logic [DM_ADDRESS-1:0] op_addr;
    logic [DATA_W-1:0]     op_wdata;
    logic [2:0]            op_f3;
    logic [1:0]            lane;
    logic [DATA_W-1:0]     word, ld_data, st_word;
    logic [7:0]            bsel;
    logic [15:0]           hsel;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && (state == IDLE);
    assign enter_resp = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd0));

    // With LATENCY == 1 the access happens on the accept edge, so the live inputs are used.
    always_comb begin
        op_we    = l_we;
        op_addr  = l_addr;
        op_wdata = l_wdata;
        op_f3    = l_f3;
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_f3    = req_funct3;
        end
    end

    always_comb begin
        lane    = op_addr[1:0];
        word    = mem[op_addr[DM_ADDRESS-1:2]];
        bsel    = word[{lane, 3'b000} +: 8];
        hsel    = word[{lane[1], 4'b0000} +: 16];
        err     = (op_f3 == 3'd3) || (op_f3 == 3'd6) || (op_f3 == 3'd7)
               || (op_f3[2] && op_we)
               || (op_f3[1:0] == 2'd1 && lane[0])
               || (op_f3 == 3'd2 && lane != 2'd0);
        ld_data = '0;
        case (op_f3)
            3'd0:    ld_data = DATA_W'($signed(bsel));
            3'd1:    ld_data = DATA_W'($signed(hsel));
            3'd2:    ld_data = word;
            3'd4:    ld_data = DATA_W'(bsel);
            3'd5:    ld_data = DATA_W'(hsel);
            default: ld_data = '0;
        endcase
        st_word = word;
        case (op_f3)
            3'd0:    st_word[{lane, 3'b000} +: 8] = op_wdata[7:0];
            3'd1:    st_word[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
            3'd2:    st_word = op_wdata;
            default: st_word = word;
        endcase
        wr_en = enter_resp && !reset && op_we && !err;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[op_addr[DM_ADDRESS-1:2]] <= st_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    l_we    <= req_we;
                    l_addr  <= req_addr;
                    l_wdata <= req_wdata;
                    l_f3    <= req_funct3;
                    state   <= WAIT;
                    cnt     <= 4'(LATENCY - 2);
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (err || op_we) ? '0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2, 1 and 15
module tb_dmem_responder;
    logic        clk;
    logic        rst  [3];
    logic        rv   [3];
    logic        rq   [3];
    logic        we   [3];
    logic [8:0]  addr [3];
    logic [31:0] wd   [3];
    logic [2:0]  f3   [3];
    logic        vld  [3];
    logic        rdy  [3];
    logic [31:0] rd   [3];
    logic        er   [3];
    logic        bsy  [3];

    int checks = 0;
    int errors = 0;
    int lat [3] = '{2, 1, 15};
    logic [32:0] exp_q [$];

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rq[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .req_funct3(f3[0]), .rsp_valid(vld[0]),
        .rsp_ready(rdy[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bsy[0]));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rq[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .req_funct3(f3[1]), .rsp_valid(vld[1]),
        .rsp_ready(rdy[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bsy[1]));
    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rq[2]), .req_we(we[2]),
        .req_addr(addr[2]), .req_wdata(wd[2]), .req_funct3(f3[2]), .rsp_valid(vld[2]),
        .rsp_ready(rdy[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; scrambles req_* after accept to prove they were latched.
    task automatic do_req(input int i, input logic w, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic [31:0] ed, input logic ee, input int hold);
        int n;
        logic [32:0] e;
        logic [31:0] held;
        n = 0;
        while (!rq[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", {31'b0, rq[i]}, 32'd1);
        rv[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d; f3[i] = f;
        exp_q.push_back({ee, ed});
        @(posedge clk);
        #1;
        rv[i] = 1'b0; we[i] = ~w; addr[i] = 9'($urandom); wd[i] = $urandom; f3[i] = 3'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld[i] && n < 40);
        chk($sformatf("latency_L%0d", lat[i]), n, lat[i]);
        e = exp_q.pop_front();
        chk($sformatf("rdata_a%03h_f%0d", a, f), rd[i], e[31:0]);
        chk($sformatf("err_a%03h_f%0d", a, f), {31'b0, er[i]}, {31'b0, e[32]});
        if (hold > 0) begin
            rdy[i] = 1'b0;
            held = rd[i];
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_valid", {31'b0, vld[i]}, 32'd1);
                chk("hold_rdata", rd[i], held);
                chk("hold_busy", {31'b0, bsy[i]}, 32'd1);
                chk("hold_req_ready", {31'b0, rq[i]}, 32'd0);
            end
            rdy[i] = 1'b1;
            @(negedge clk);
            chk("release_valid", {31'b0, vld[i]}, 32'd0);
            chk("release_busy", {31'b0, bsy[i]}, 32'd0);
            chk("release_req_ready", {31'b0, rq[i]}, 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rv[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
            wd[i] = '0; f3[i] = '0; rdy[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, rq[0]}, 32'd1);
        chk("reset_busy", {31'b0, bsy[0]}, 32'd0);
        chk("reset_valid", {31'b0, vld[0]}, 32'd0);
        chk("reset_err", {31'b0, er[0]}, 32'd0);
        chk("reset_rdata", rd[0], 32'd0);

        do_req(0, 1, 9'h010, 32'h12345678, 3'd2, 32'h0, 1'b0, 0);
        do_req(0, 0, 9'h010, 32'h0,        3'd2, 32'h12345678, 1'b0, 0);
        do_req(0, 1, 9'h004, 32'h0,        3'd2, 32'h0, 1'b0, 0);
        do_req(0, 1, 9'h005, 32'h123456AB, 3'd0, 32'h0, 1'b0, 0);
        do_req(0, 0, 9'h005, 32'h0,        3'd0, 32'hFFFFFFAB, 1'b0, 0);
        do_req(0, 0, 9'h005, 32'h0,        3'd4, 32'h000000AB, 1'b0, 0);
        do_req(0, 0, 9'h004, 32'h0,        3'd2, 32'h0000AB00, 1'b0, 0);
        do_req(0, 0, 9'h004, 32'h0,        3'd1, 32'hFFFFAB00, 1'b0, 0);
        do_req(0, 0, 9'h006, 32'h0,        3'd5, 32'h00000000, 1'b0, 0);
        do_req(0, 1, 9'h000, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0, 0);
        do_req(0, 0, 9'h002, 32'h0,        3'd2, 32'h0, 1'b1, 0);
        do_req(0, 1, 9'h003, 32'h0000BEEF, 3'd1, 32'h0, 1'b1, 0);
        do_req(0, 0, 9'h000, 32'h0,        3'd2, 32'hCAFEF00D, 1'b0, 0);
        do_req(0, 0, 9'h000, 32'h0,        3'd7, 32'h0, 1'b1, 0);
        do_req(0, 1, 9'h000, 32'hFFFFFFFF, 3'd4, 32'h0, 1'b1, 0);
        do_req(0, 1, 9'h002, 32'h1234BEEF, 3'd1, 32'h0, 1'b0, 0);
        do_req(0, 0, 9'h000, 32'h0,        3'd2, 32'hBEEFF00D, 1'b0, 0);
        do_req(0, 0, 9'h002, 32'h0,        3'd1, 32'hFFFFBEEF, 1'b0, 0);
        do_req(0, 0, 9'h010, 32'h0,        3'd2, 32'h12345678, 1'b0, 3);

        do_req(0, 1, 9'h020, 32'h5A5A5A5A, 3'd2, 32'h0, 1'b0, 0);
        @(negedge clk);
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'h020; wd[0] = 32'hFFFFFFFF; f3[0] = 3'd2;
        @(posedge clk);
        #1;
        rv[0] = 1'b0; rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", {31'b0, rq[0]}, 32'd1);
        chk("abort_valid", {31'b0, vld[0]}, 32'd0);
        do_req(0, 0, 9'h020, 32'h0, 3'd2, 32'h5A5A5A5A, 1'b0, 0);

        for (int i = 1; i < 3; i++) begin
            do_req(i, 1, 9'h010, 32'h12345678, 3'd2, 32'h0, 1'b0, 0);
            do_req(i, 0, 9'h010, 32'h0,        3'd2, 32'h12345678, 1'b0, 0);
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9: request byte-address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter LATENCY, default 2, legal 1..15: cycles from request accept to first response cycle.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  the pipeline MEM stage presents a load or store.
REQ-007 req_ready  output  1  the block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  DM_ADDRESS  byte address.
REQ-010 req_wdata  input  DATA_W  store data; the relevant bytes are the low bytes.
REQ-011 req_funct3  input  3  RV32I width code: 0 = b, 1 = h, 2 = w, 4 = bu, 5 = hu.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  the pipeline consumes the response.
REQ-014 rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned access or illegal funct3.
REQ-016 busy  output  1  stall request to the pipeline; high whenever the state is not IDLE.

Function
REQ-017 The block SHALL hold 2^DM_ADDRESS bytes as 2^(DM_ADDRESS-2) little-endian words, indexed by req_addr[DM_ADDRESS-1:2].
REQ-018 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-020 On accept, the block SHALL latch we, addr, wdata and funct3; later changes on the req_* inputs SHALL have no effect.
REQ-021 Accept with LATENCY = 1: IDLE goes to RESP. Accept with LATENCY > 1: IDLE goes to WAIT and a down-counter is loaded with LATENCY-2.
REQ-022 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-023 For a request accepted at edge k, rsp_valid SHALL first be 1 in the cycle after edge k+LATENCY-1 (i.e. LATENCY cycles after accept).
REQ-024 The memory read or write SHALL take effect on the edge that enters RESP, and rsp_rdata/rsp_err SHALL be registered on that same edge.
REQ-025 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until an edge with rsp_ready = 1, then go to IDLE.
REQ-026 No new request SHALL be accepted in the cycle in which RESP exits; the minimum request spacing is LATENCY+1 cycles.
REQ-027 Error cases SHALL set rsp_err = 1, rsp_rdata = 0 and suppress any write:
  - funct3 = 3, 6 or 7, for any access;
  - funct3 = 4 or 5 with req_we = 1;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0.
REQ-028 Loads SHALL select bytes by addr[1:0]:
  - b: sign-extend byte addr[1:0];
  - bu: zero-extend that byte;
  - h: sign-extend half addr[1];
  - hu: zero-extend that half;
  - w: whole word.
REQ-029 Stores SHALL write only the addressed bytes:
  - sb: wdata[7:0] to byte addr[1:0];
  - sh: wdata[15:0] to half addr[1];
  - sw: all four bytes;
  - untouched bytes SHALL keep their previous value.
REQ-030 A store's response SHALL have rsp_rdata = 0 and rsp_err = 0 when legal.
REQ-031 A load of a location SHALL return the data of the most recent completed store to it, with no forwarding window.
REQ-032 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-033 While reset = 1 at an edge: state becomes IDLE, the counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0.
REQ-034 After reset: req_ready = 1 and busy = 0 from the first cycle.
REQ-035 Reset in WAIT or RESP SHALL abandon the transaction; a store that has not yet reached RESP SHALL NOT be written.
REQ-036 Memory contents SHALL NOT be changed by reset.

Verification
REQ-037 LATENCY=2: sw 0x12345678 to 0x010, then lw 0x010 -> rsp_rdata = 0x12345678, rsp_err = 0; rsp_valid exactly 2 cycles after each accept.
REQ-038 sb 0xAB to 0x005 over a word holding 0x00000000 -> lb 0x005 = 0xFFFFFFAB, lbu 0x005 = 0x000000AB, lw 0x004 = 0x0000AB00.
REQ-039 Error cases: lw 0x002 -> rsp_err = 1, rsp_rdata = 0; sh 0xBEEF to 0x003 -> rsp_err = 1 and lw 0x000 returns its prior value; funct3 = 7 -> rsp_err = 1.
REQ-040 Back-pressure: hold rsp_ready = 0 for 3 cycles in RESP -> rsp_valid/rsp_rdata stable, busy = 1, req_ready = 0; release -> IDLE next cycle.
REQ-041 Reset during WAIT of sw 0xFFFFFFFF to 0x020 -> next cycle req_ready = 1, rsp_valid = 0; lw 0x020 returns the pre-store value.
REQ-042 Repeat REQ-037 with LATENCY = 1 and LATENCY = 15 -> first rsp_valid 1 and 15 cycles after accept, respectively.
